vn_bit_collector: RTL and testbench

//   Sink end of the decorrelated bit stream: consumes sparse (bit, syn) pairs from the
//   von Neumann decorrelator and packs them MSB-first into WORD_WIDTH-bit words.

---
 rtl/vn_bit_collector.sv | 101 ++++++++++
 tb/tb_vn_bit_collector.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vn_bit_collector.sv
// Packs sparse decorrelated bits MSB-first into WORD_WIDTH-bit words, double-buffered
// behind a valid/ack handshake, with a sticky flag for bits dropped while the buffer is full.
module vn_bit_collector #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  bit_in,
    input  logic                  syn_in,
    output logic [WORD_WIDTH-1:0] word_out,
    output logic                  word_valid,
    input  logic                  word_ack,
    output logic                  overflow,
    input  logic                  overflow_clear
);

    localparam int CNT_W = $clog2(WORD_WIDTH + 1);

    typedef enum logic {
        COLLECT,
        FULL
    } state_t;

    state_t                state, state_nxt;
    logic [WORD_WIDTH-1:0] shift_reg, shift_nxt;
    logic [WORD_WIDTH-1:0] word_nxt;
    logic [CNT_W-1:0]      bit_cnt, cnt_nxt;
    logic                  valid_nxt;
    logic                  overflow_nxt;
    logic                  transfer;
    logic                  accept;
    logic                  drop;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_nxt    = state;
        shift_nxt    = shift_reg;
        word_nxt     = word_out;
        cnt_nxt      = bit_cnt;
        valid_nxt    = word_valid;
        overflow_nxt = overflow;

        transfer = (state == FULL) && (!word_valid || word_ack);
        accept   = syn_in && enable && ((state == COLLECT) || transfer);
        drop     = syn_in && enable && (state == FULL) && !transfer;

        // A pending word moves to the output register before any enable-driven flush.
        if (transfer) begin
            word_nxt  = shift_reg;
            valid_nxt = 1'b1;
            cnt_nxt   = '0;
            state_nxt = COLLECT;
        end else if (word_valid && word_ack) begin
            valid_nxt = 1'b0;
        end

        if (!enable) begin
            cnt_nxt   = '0;
            state_nxt = COLLECT;
            shift_nxt = '0;
        end else if (accept) begin
            shift_nxt = {shift_reg[WORD_WIDTH-2:0], bit_in};
            if (transfer) begin
                cnt_nxt = CNT_W'(1);
            end else begin
                cnt_nxt = bit_cnt + CNT_W'(1);
                if (bit_cnt == CNT_W'(WORD_WIDTH - 1)) begin
                    state_nxt = FULL;
                end
            end
        end

        // A drop in the same cycle as a clear must still leave the flag set.
        if (drop) begin
            overflow_nxt = 1'b1;
        end else if (overflow_clear) begin
            overflow_nxt = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= COLLECT;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift_reg  <= shift_nxt;
            bit_cnt    <= cnt_nxt;
            word_out   <= word_nxt;
            word_valid <= valid_nxt;
            overflow   <= overflow_nxt;
        end
    end

endmodule

// File: tb/tb_vn_bit_collector.sv
// Self-checking bench for vn_bit_collector: table-driven vectors at WORD_WIDTH=8 plus
// directed multi-cycle sequences, and one 32-bit instance for the wide-word case.
module tb_vn_bit_collector;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        enable = 1'b0, bit_in = 1'b0, syn_in = 1'b0;
    logic        word_ack = 1'b0, overflow_clear = 1'b0;
    logic [7:0]  word_out;
    logic        word_valid, overflow;

    logic        en32 = 1'b0, bit32 = 1'b0, syn32 = 1'b0;
    logic        ack32 = 1'b0, clr32 = 1'b0;
    logic [31:0] word32;
    logic        valid32, ovf32;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vn_bit_collector #(.WORD_WIDTH(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .bit_in(bit_in), .syn_in(syn_in),
        .word_out(word_out), .word_valid(word_valid), .word_ack(word_ack),
        .overflow(overflow), .overflow_clear(overflow_clear)
    );

    vn_bit_collector #(.WORD_WIDTH(32)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .enable(en32), .bit_in(bit32), .syn_in(syn32),
        .word_out(word32), .word_valid(valid32), .word_ack(ack32),
        .overflow(ovf32), .overflow_clear(clr32)
    );

    typedef struct {
        logic       en;
        logic       syn;
        logic       bit_v;
        logic       ack;
        logic       clr;
        logic       exp_valid;
        logic [7:0] exp_word;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input logic en, input logic syn, input logic b, input logic ack,
                       input logic clr, input logic v, input logic [7:0] w, input logic o);
        vec_t t;
        t.en = en; t.syn = syn; t.bit_v = b; t.ack = ack; t.clr = clr;
        t.exp_valid = v; t.exp_word = w; t.exp_ovf = o;
        vecs.push_back(t);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            bit_in = b[i];
            syn_in = 1'b1;
            step();
        end
        syn_in = 1'b0;
    endtask

    logic [7:0]  t3_words[8];
    logic [7:0]  t4_bits;
    logic [7:0]  got[$];
    logic [31:0] pat32;

    initial begin
        // Word B2 with gaps of 0,1,2,3 idle cycles, left pending (no ack).
        add(1,1,1,0,0, 0,8'h00,0);
        add(1,1,0,0,0, 0,8'h00,0);
        add(1,0,0,0,0, 0,8'h00,0);
        add(1,1,1,0,0, 0,8'h00,0);
        add(1,0,0,0,0, 0,8'h00,0);
        add(1,0,0,0,0, 0,8'h00,0);
        add(1,1,1,0,0, 0,8'h00,0);
        add(1,0,0,0,0, 0,8'h00,0);
        add(1,0,0,0,0, 0,8'h00,0);
        add(1,0,0,0,0, 0,8'h00,0);
        add(1,1,0,0,0, 0,8'h00,0);
        add(1,1,0,0,0, 0,8'h00,0);
        add(1,1,1,0,0, 0,8'h00,0);
        add(1,1,0,0,0, 0,8'h00,0);
        add(1,0,0,0,0, 1,8'hB2,0);
        // Five bits, enable dropped for one cycle (syn ignored), then eight bits 0x69.
        for (int i = 0; i < 5; i++) add(1,1,1,0,0, 1,8'hB2,0);
        add(0,1,1,0,0, 1,8'hB2,0);
        t4_bits = 8'h69;
        for (int i = 7; i >= 0; i--) add(1,1,t4_bits[i],0,0, 1,8'hB2,0);
        add(1,0,0,0,0, 1,8'hB2,0);
        add(1,0,0,1,0, 1,8'h69,0);
        add(1,0,0,1,0, 0,8'h69,0);

        repeat (3) @(negedge clk);
        check("reset valid8", word_valid, 1'b0);
        check("reset word8", word_out, 8'h00);
        check("reset ovf8", overflow, 1'b0);
        check("reset valid32", valid32, 1'b0);
        check("reset word32", word32, 32'h0);
        reset_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            enable = vecs[i].en; syn_in = vecs[i].syn; bit_in = vecs[i].bit_v;
            word_ack = vecs[i].ack; overflow_clear = vecs[i].clr;
            step();
            check($sformatf("vec%0d valid", i), word_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d word", i), word_out, vecs[i].exp_word);
            check($sformatf("vec%0d ovf", i), overflow, vecs[i].exp_ovf);
        end
        syn_in = 1'b0; word_ack = 1'b0; overflow_clear = 1'b0; enable = 1'b1;

        // Two words with no ack: second waits in FULL, extra bits are dropped.
        send_byte(8'hA5);
        step();
        check("t2 first valid", word_valid, 1'b1);
        check("t2 first word", word_out, 8'hA5);
        send_byte(8'h3C);
        check("t2 full no ovf", overflow, 1'b0);
        check("t2 word held", word_out, 8'hA5);
        for (int i = 0; i < 3; i++) begin
            bit_in = i[0]; syn_in = 1'b1;
            step();
        end
        syn_in = 1'b0;
        check("t2 ovf set", overflow, 1'b1);
        check("t2 word stable", word_out, 8'hA5);
        overflow_clear = 1'b1;
        step();
        check("t5 clear", overflow, 1'b0);
        syn_in = 1'b1; bit_in = 1'b1;
        step();
        check("t5 set wins", overflow, 1'b1);
        syn_in = 1'b0;
        step();
        check("t5 clear alone", overflow, 1'b0);
        overflow_clear = 1'b0;
        word_ack = 1'b1;
        step();
        check("t2 back2back valid", word_valid, 1'b1);
        check("t2 second word", word_out, 8'h3C);
        step();
        check("t2 drained", word_valid, 1'b0);

        // Ack held high with a bit every cycle: transfer-cycle bits start the next word.
        t3_words = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        for (int i = 0; i < 64; i++) begin
            bit_in = t3_words[i / 8][7 - (i % 8)];
            syn_in = 1'b1;
            step();
            if (word_valid) got.push_back(word_out);
        end
        syn_in = 1'b0;
        step();
        if (word_valid) got.push_back(word_out);
        step();
        check("t3 word count", got.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < got.size()) check($sformatf("t3 word%0d", k), got[k], t3_words[k]);
        end
        check("t3 no ovf", overflow, 1'b0);
        check("t3 idle", word_valid, 1'b0);
        word_ack = 1'b0;

        // Reset mid-word with a pending output word.
        send_byte(8'h5A);
        step();
        check("t6 pending", word_valid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bit_in = 1'b1; syn_in = 1'b1;
            step();
        end
        syn_in = 1'b0;
        reset_n = 1'b0;
        #1;
        check("t6 rst valid", word_valid, 1'b0);
        check("t6 rst word", word_out, 8'h00);
        check("t6 rst ovf", overflow, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        send_byte(8'hC3);
        step();
        check("t6 fresh valid", word_valid, 1'b1);
        check("t6 fresh word", word_out, 8'hC3);
        check("t6 fresh ovf", overflow, 1'b0);

        // 32-bit word B2B2B2B2 with gaps cycling 0..3.
        en32 = 1'b1;
        pat32 = 32'hB2B2_B2B2;
        for (int k = 0; k < 32; k++) begin
            bit32 = pat32[31 - k];
            syn32 = 1'b1;
            step();
            syn32 = 1'b0;
            if (k == 31) check("w32 not yet valid", valid32, 1'b0);
            else repeat (k % 4) step();
        end
        step();
        check("w32 valid", valid32, 1'b1);
        check("w32 word", word32, 32'hB2B2_B2B2);
        check("w32 ovf", ovf32, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
